// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a length-prefixed big-endian byte stream into 16-bit words.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StChk, StDone, StErr
  } state_e;
  localparam state_e StEnd = StChk;
`else
  typedef enum logic [3:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StDone, StErr
  } state_e;
  localparam state_e StEnd = StDone;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q;
  logic [15:0]       len_next;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              core_en_q, done_q, err_q;
  logic              accept;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  assign accept    = byte_valid && byte_ready;
  assign len_next  = {len_q[15:8], byte_in};
  assign last_word = (32'(count_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b1;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        byte_ready = 1'b1;
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        byte_ready = 1'b1;
        if (accept) begin
          if (32'(len_next) > MAX_WORDS) state_d = StErr;
          else if (len_next == 16'd0)    state_d = StEnd;
          else                           state_d = StDataHi;
        end
      end
      StDataHi: begin
        byte_ready = 1'b1;
        if (accept) state_d = StDataLo;
      end
      StDataLo: begin
        byte_ready = 1'b1;
        if (accept) state_d = StWrite;
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = last_word ? StEnd : StDataHi;
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        byte_ready = 1'b1;
        if (accept) state_d = (byte_in == xor_q) ? StDone : StErr;
      end
`endif
      StDone, StErr: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_en_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        addr_q    <= ADDR_W'(BASE_ADDR);
        count_q   <= '0;
        core_en_q <= 1'b0;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_q     <= '0;
`endif
      end
      if (state_q == StLenHi && accept) len_q[15:8] <= byte_in;
      if (state_q == StLenLo && accept) len_q[7:0] <= byte_in;
      if (state_q == StDataHi && accept) hi_q <= byte_in;
      // Output registers only change on a word, so they hold between writes.
      if (state_q == StDataLo && accept) begin
        mem_wdata_q <= {hi_q, byte_in};
        mem_addr_q  <= addr_q;
      end
      if (state_q == StWrite) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (accept && state_q != StChk) xor_q <= xor_q ^ byte_in;
`endif
      if (state_d == StDone) begin
        done_q    <= 1'b1;
        core_en_q <= 1'b1;
      end
      if (state_d == StErr) begin
        err_q     <= 1'b1;
        core_en_q <= 1'b0;
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_en    = core_en_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader; follows LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              core_en, busy, done, err;
  logic [ADDR_W:0]   word_count;

  int errors = 0;
  int checks = 0;
  bit tog = 1'b0;
  logic [ADDR_W+15:0] exp_q[$];
  logic [15:0]        wq[$];

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .core_en(core_en), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int mode);
    int  t = 0;
    bit  sent = 1'b0;
    while (!sent) begin
      bit v;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) begin v = tog; tog = ~tog; end
      else                v = 1'($urandom);
      byte_valid = v;
      byte_in    = v ? b : 8'($urandom);
      @(negedge clk);
      if (v && byte_ready) sent = 1'b1;
      @(posedge clk);
      #1;
      t++;
      if (!sent && t > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: got no byte_ready expected acceptance of %0h", b);
        sent = 1'b1;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Reference model: builds the stream from wq and the length field, predicts writes and status.
  task automatic run_load(input logic [15:0] n, input int mode, input logic [7:0] bad);
    logic [7:0] stream[$];
    logic [7:0] x = '0;
    bit         fits = 32'(n) <= MAX_WORDS;
    bit         ok;
    int         lat;
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    if (fits) begin
      for (int i = 0; i < int'(n); i++) begin
        stream.push_back(wq[i][15:8]);
        stream.push_back(wq[i][7:0]);
        exp_q.push_back({ADDR_W'(BASE_ADDR + i), wq[i]});
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (fits) begin
      foreach (stream[i]) x ^= stream[i];
      stream.push_back(x ^ bad);
    end
    ok  = fits && bad == 8'd0;
    lat = 1;
`else
    ok  = fits;
    lat = (fits && n != 16'd0) ? 2 : 1;
`endif
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("core_en_after_start", core_en, 0);
    check("flags_after_start", {done, err}, 0);
    check("wc_after_start", word_count, 0);
    @(posedge clk);
    #1;
    foreach (stream[i]) send_byte(stream[i], mode);
    repeat (lat) @(negedge clk);
    check("busy_end", busy, 0);
    check("done_end", done, ok);
    check("err_end", err, !ok);
    check("core_en_end", core_en, ok);
    check("wc_end", word_count, fits ? 32'(n) : 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_ready", byte_ready, 0);
    check("done_sticky", done, ok);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_core_en", core_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_flags", {done, err}, 0);
    check("rst_wc", word_count, 0);

    wq = '{16'h1234, 16'hABCD};
    run_load(16'd2, 0, 8'h00);
    run_load(16'd2, 1, 8'h00);
    run_load(16'd257, 0, 8'h00);
    run_load(16'd0, 0, 8'h00);

    // Abort a 4-word load after its first word.
    wq = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    exp_q.push_back({ADDR_W'(BASE_ADDR), 16'h1122});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {byte_ready, busy, done, err, core_en, mem_we}, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_wc", word_count, 0);
    check("abort_pending", exp_q.size(), 0);
    run_load(16'd4, 2, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    wq = '{16'h1234};
    run_load(16'd1, 0, 8'h00);
    run_load(16'd1, 0, 8'h0F);
`endif

    wq.delete();
    for (int i = 0; i < int'(MAX_WORDS); i++) wq.push_back(16'($urandom));
    run_load(16'(MAX_WORDS), 0, 8'h00);

    for (int k = 0; k < 30; k++) begin
      logic [15:0] n;
      logic [7:0]  bad = 8'h00;
      wq.delete();
      if ($urandom_range(0, 5) == 0) n = 16'($urandom_range(MAX_WORDS + 1, 65535));
      else                           n = 16'($urandom_range(0, 8));
      for (int i = 0; i < int'(n) && i < 8; i++) wq.push_back(16'($urandom));
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) bad = 8'($urandom_range(1, 255));
`endif
      run_load(n, int'($urandom_range(0, 2)), bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-fetch path. The fetch unit reads 16-bit opcodes from instruction memory indexed by PC[7:0]; this block fills that memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. Writes the words to consecutive instruction-memory addresses.
- Holds the core's fetch enable low while loading and raises it once the load completes.

Parameters:
- ADDR_W, 8, instruction-memory address width; matches the PC[7:0] fetch index.
- BASE_ADDR, 0, address of the first loaded word.
- MAX_WORDS, 256, largest word count accepted; must be <= 2**ADDR_W - BASE_ADDR.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored while busy=1.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  instruction-memory write address.
- mem_wdata  output  16  instruction word to write.
- mem_we  output  1  write strobe, one cycle per word.
- core_en  output  1  drives the fetch unit's en input; 1 = core running.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully; sticky.
- err  output  1  last load failed; sticky.
- word_count  output  ADDR_W+1  number of words written so far in the current or last load.

Behaviour:
- Reset values: all outputs 0; state IDLE.
  - core_en stays 0 until the first successful load.
  - rst asserted mid-load aborts immediately. Partial memory contents are left as written.
- Byte accepted on a rising edge where byte_valid && byte_ready. byte_ready is combinational from state only, never from byte_valid.
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N words, each sent high byte then low byte. A checksum byte follows only when the optional feature is enabled.
- States:
  - IDLE: byte_ready=0; busy=0.
    - start=1: next state LEN_HI; busy=1, core_en=0, done=0, err=0, word_count=0, address = BASE_ADDR.
  - LEN_HI / LEN_LO: byte_ready=1; capture N.
    - After LEN_LO, if N > MAX_WORDS go to ERR.
    - If N == 0 go to CHK (feature on) or DONE (feature off).
    - Otherwise go to DATA_HI.
  - DATA_HI: byte_ready=1; latch the high byte; go to DATA_LO.
  - DATA_LO: byte_ready=1; latch the low byte; go to WRITE.
  - WRITE: one cycle, byte_ready=0.
    - mem_we=1, mem_wdata = {hi, lo}, mem_addr = current address.
    - Next edge: address+1, word_count+1.
    - If word_count+1 == N, go to CHK or DONE; else go to DATA_HI.
  - CHK (feature only): see Optional Feature.
  - DONE: one cycle; done=1, core_en=1, busy=0; go to IDLE.
  - ERR: one cycle; err=1, core_en=0, busy=0; go to IDLE.
- Timing:
  - Minimum 3 cycles per word (2 bytes + WRITE).
  - core_en rises on the cycle after the final WRITE (feature off).
  - core_en falls on the edge after start is sampled.
- Address wrap cannot occur; it is excluded by the MAX_WORDS check.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- done and err are mutually exclusive. Both clear on an accepted start.
- byte_valid while byte_ready=0 is ignored, with no effect on state.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted byte is kept, including the length bytes.
  - After the last word, or after LEN_LO when N == 0, enter CHK with byte_ready=1.
  - The accepted byte must equal the running XOR. Match goes to DONE; mismatch goes to ERR.
  - Memory already written stays written, but core_en remains 0 on mismatch.
- Undefined: no CHK state and no XOR register; the stream ends after the last data byte.

Test Plan:
- Reset, then idle 5 cycles -> core_en=0, busy=0, byte_ready=0, mem_we=0.
- start, bytes 00 02 12 34 AB CD, valid every cycle -> writes 0x1234 @0 and 0xABCD @1, mem_we asserted exactly twice; done=1, core_en=1 after the final write, word_count=2.
- Same stream with byte_valid toggling 1/0 each cycle -> identical writes, no duplicated or dropped bytes.
- start, bytes 01 01 (N=257 > MAX_WORDS) -> no mem_we; err=1, core_en=0.
- rst asserted after the first data word of a 4-word load -> all outputs 0, state IDLE; a following start loads correctly from BASE_ADDR.
- With LOADER_CHECKSUM_EN: 00 01 12 34 + checksum 0x27 -> done=1. Repeat with checksum 0x28 -> err=1, core_en=0.
